// File: rtl/rgb_scene_sequencer_pkg.sv
// Shared definitions for the RGB scene sequencer: mode/state encodings,
// duty and PWM-frequency constants, and the PARTY colour table.
package rgb_scene_sequencer_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_DIM   = 3'd1,
    MODE_MID   = 3'd2,
    MODE_FULL  = 3'd3,
    MODE_PARTY = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FADE,
    SEQ_HOLD
  } seq_state_t;

  localparam logic [11:0] DUTY_OFF  = 12'd0;
  localparam logic [11:0] DUTY_DIM  = 12'd333;
  localparam logic [11:0] DUTY_MID  = 12'd666;
  localparam logic [11:0] DUTY_FULL = 12'd999;
  localparam logic [11:0] DUTY_MAX  = 12'd1000;

  localparam logic [6:0] FREQ_STATIC = 7'd100;
  localparam logic [6:0] FREQ_PARTY  = 7'd1;

  typedef struct packed {
    logic [11:0] r;
    logic [11:0] g;
    logic [11:0] b;
  } rgb_t;

  function automatic rgb_t scene_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = '{r: DUTY_MAX, g: 12'd0,    b: 12'd0};
      3'd1:    c = '{r: DUTY_MAX, g: 12'd500,  b: 12'd0};
      3'd2:    c = '{r: DUTY_MAX, g: DUTY_MAX, b: 12'd0};
      3'd3:    c = '{r: 12'd0,    g: DUTY_MAX, b: 12'd0};
      3'd4:    c = '{r: 12'd0,    g: DUTY_MAX, b: DUTY_MAX};
      3'd5:    c = '{r: 12'd0,    g: 12'd0,    b: DUTY_MAX};
      3'd6:    c = '{r: 12'd500,  g: 12'd0,    b: DUTY_MAX};
      default: c = '{r: DUTY_MAX, g: DUTY_MAX, b: DUTY_MAX};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// One channel's saturating step toward a target duty; o_at_target reports
// whether the proposed next value lands exactly on the target.
module duty_ramp #(
  parameter int unsigned STEP = 10
) (
  input  logic [11:0] i_duty,
  input  logic [11:0] i_target,
  output logic [11:0] o_next,
  output logic        o_at_target
);

  localparam logic [11:0] STEP_W = 12'(STEP);

  logic        w_up;
  logic [11:0] w_dist;

  always_comb begin
    w_up   = i_target > i_duty;
    w_dist = w_up ? (i_target - i_duty) : (i_duty - i_target);
    if (w_dist <= STEP_W) begin
      o_next = i_target;
    end else if (w_up) begin
      o_next = i_duty + STEP_W;
    end else begin
      o_next = i_duty - STEP_W;
    end
    o_at_target = (o_next == i_target);
  end

endmodule

// File: rtl/rgb_scene_sequencer.sv
// Mode ring and PARTY fade/hold sequencer producing registered per-channel
// duties on the 0..1000 scale for three PWM channels.
module rgb_scene_sequencer
  import rgb_scene_sequencer_pkg::*;
#(
  parameter int unsigned STEP    = 10,
  parameter int unsigned HOLD_MS = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode_next,
  input  logic        tick_1ms,
  input  logic        pause,
  output logic [2:0]  mode,
  output logic [2:0]  scene_idx,
  output logic        party_mode_flag,
  output logic [11:0] duty_r,
  output logic [11:0] duty_g,
  output logic [11:0] duty_b,
  output logic [6:0]  pwm_freq
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);

  mode_t       r_mode;
  seq_state_t  r_state;
  logic [2:0]  r_scene;
  logic [15:0] r_hold_cnt;
  logic [11:0] r_duty_r, r_duty_g, r_duty_b;
  logic        r_flag;
  logic [6:0]  r_freq;

  rgb_t        w_target;
  logic [11:0] w_next_r, w_next_g, w_next_b;
  logic        w_at_r, w_at_g, w_at_b;

  // Target is always the table entry of the current scene, so it needs no register.
  assign w_target = scene_colour(r_scene);

  duty_ramp #(.STEP(STEP)) u_ramp_r (
    .i_duty(r_duty_r), .i_target(w_target.r), .o_next(w_next_r), .o_at_target(w_at_r)
  );
  duty_ramp #(.STEP(STEP)) u_ramp_g (
    .i_duty(r_duty_g), .i_target(w_target.g), .o_next(w_next_g), .o_at_target(w_at_g)
  );
  duty_ramp #(.STEP(STEP)) u_ramp_b (
    .i_duty(r_duty_b), .i_target(w_target.b), .o_next(w_next_b), .o_at_target(w_at_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= MODE_OFF;
      r_state    <= SEQ_IDLE;
      r_scene    <= '0;
      r_hold_cnt <= '0;
      r_duty_r   <= '0;
      r_duty_g   <= '0;
      r_duty_b   <= '0;
      r_flag     <= 1'b0;
      r_freq     <= FREQ_STATIC;
    end else if (mode_next) begin
      case (r_mode)
        MODE_OFF: begin
          r_mode   <= MODE_DIM;
          r_state  <= SEQ_IDLE;
          r_duty_r <= DUTY_DIM;
          r_duty_g <= DUTY_DIM;
          r_duty_b <= DUTY_DIM;
        end
        MODE_DIM: begin
          r_mode   <= MODE_MID;
          r_state  <= SEQ_IDLE;
          r_duty_r <= DUTY_MID;
          r_duty_g <= DUTY_MID;
          r_duty_b <= DUTY_MID;
        end
        MODE_MID: begin
          r_mode   <= MODE_FULL;
          r_state  <= SEQ_IDLE;
          r_duty_r <= DUTY_FULL;
          r_duty_g <= DUTY_FULL;
          r_duty_b <= DUTY_FULL;
        end
        MODE_FULL: begin
          r_mode     <= MODE_PARTY;
          r_state    <= SEQ_FADE;
          r_scene    <= '0;
          r_hold_cnt <= '0;
          r_flag     <= 1'b1;
          r_freq     <= FREQ_PARTY;
        end
        default: begin
          r_mode     <= MODE_OFF;
          r_state    <= SEQ_IDLE;
          r_scene    <= '0;
          r_hold_cnt <= '0;
          r_duty_r   <= DUTY_OFF;
          r_duty_g   <= DUTY_OFF;
          r_duty_b   <= DUTY_OFF;
          r_flag     <= 1'b0;
          r_freq     <= FREQ_STATIC;
        end
      endcase
    end else begin
      case (r_mode)
        MODE_OFF, MODE_DIM, MODE_MID, MODE_FULL: ;
        MODE_PARTY: begin
          if (tick_1ms && !pause) begin
            case (r_state)
              SEQ_FADE: begin
                r_duty_r <= w_next_r;
                r_duty_g <= w_next_g;
                r_duty_b <= w_next_b;
                if (w_at_r && w_at_g && w_at_b) begin
                  r_state    <= SEQ_HOLD;
                  r_hold_cnt <= '0;
                end
              end
              SEQ_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                  r_scene    <= r_scene + 3'd1;
                  r_state    <= SEQ_FADE;
                  r_hold_cnt <= '0;
                end else begin
                  r_hold_cnt <= r_hold_cnt + 16'd1;
                end
              end
              default: r_state <= SEQ_FADE;
            endcase
          end
        end
        default: begin
          r_mode     <= MODE_OFF;
          r_state    <= SEQ_IDLE;
          r_scene    <= '0;
          r_hold_cnt <= '0;
          r_duty_r   <= DUTY_OFF;
          r_duty_g   <= DUTY_OFF;
          r_duty_b   <= DUTY_OFF;
          r_flag     <= 1'b0;
          r_freq     <= FREQ_STATIC;
        end
      endcase
    end
  end

  assign mode            = r_mode;
  assign scene_idx       = r_scene;
  assign party_mode_flag = r_flag;
  assign duty_r          = r_duty_r;
  assign duty_g          = r_duty_g;
  assign duty_b          = r_duty_b;
  assign pwm_freq        = r_freq;

endmodule

// File: tb/tb_rgb_scene_sequencer.sv
// Randomised and directed bench for rgb_scene_sequencer against a behavioural
// model of the mode ring and PARTY colour sequence.
module tb_rgb_scene_sequencer;

  localparam int STEP    = 10;
  localparam int HOLD_MS = 500;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode_next;
  logic        tick_1ms;
  logic        pause;
  logic [2:0]  mode;
  logic [2:0]  scene_idx;
  logic        party_mode_flag;
  logic [11:0] duty_r, duty_g, duty_b;
  logic [6:0]  pwm_freq;

  always #5 clk = ~clk;

  rgb_scene_sequencer #(.STEP(STEP), .HOLD_MS(HOLD_MS)) dut (
    .clk(clk), .reset_n(reset_n), .mode_next(mode_next), .tick_1ms(tick_1ms),
    .pause(pause), .mode(mode), .scene_idx(scene_idx),
    .party_mode_flag(party_mode_flag), .duty_r(duty_r), .duty_g(duty_g),
    .duty_b(duty_b), .pwm_freq(pwm_freq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Colour table, one array per channel, indexed by scene.
  int tbl[3][8] = '{'{1000, 1000, 1000,    0,    0,    0,  500, 1000},
                    '{   0,  500, 1000, 1000, 1000,    0,    0, 1000},
                    '{   0,    0,    0,    0, 1000, 1000, 1000, 1000}};

  int m_mode, m_scene, m_hold;
  int m_d[3];
  bit m_fading, m_holding;

  function automatic void model_reset();
    m_mode = 0; m_scene = 0; m_hold = 0;
    m_d = '{0, 0, 0};
    m_fading = 0; m_holding = 0;
  endfunction

  function automatic void model_edge(bit mn, bit tk, bit ps);
    int  diff;
    bit  done;
    if (mn) begin
      if (m_mode == 4) begin
        model_reset();
      end else begin
        m_mode++;
        if (m_mode < 4) begin
          for (int c = 0; c < 3; c++) m_d[c] = 333 * m_mode;
        end else begin
          m_scene = 0; m_hold = 0; m_fading = 1; m_holding = 0;
        end
      end
    end else if (m_mode == 4 && tk && !ps) begin
      if (m_fading) begin
        done = 1;
        for (int c = 0; c < 3; c++) begin
          diff = tbl[c][m_scene] - m_d[c];
          if (diff >= -STEP && diff <= STEP) m_d[c] = tbl[c][m_scene];
          else if (diff > 0)                 m_d[c] = m_d[c] + STEP;
          else                               m_d[c] = m_d[c] - STEP;
          if (m_d[c] != tbl[c][m_scene]) done = 0;
        end
        if (done) begin
          m_fading = 0; m_holding = 1; m_hold = 0;
        end
      end else if (m_holding) begin
        m_hold++;
        if (m_hold == HOLD_MS) begin
          m_scene = (m_scene + 1) % 8;
          m_holding = 0; m_fading = 1; m_hold = 0;
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("mode",  mode, m_mode);
    check("scene", scene_idx, m_scene);
    check("flag",  party_mode_flag, (m_mode == 4) ? 1 : 0);
    check("duty_r", duty_r, m_d[0]);
    check("duty_g", duty_g, m_d[1]);
    check("duty_b", duty_b, m_d[2]);
    check("freq",  pwm_freq, (m_mode == 4) ? 1 : 100);
  endtask

  task automatic cycle(input bit mn, input bit tk, input bit ps);
    @(negedge clk);
    mode_next = mn; tick_1ms = tk; pause = ps;
    @(posedge clk);
    model_edge(mn, tk, ps);
    #1;
    compare_all();
  endtask

  initial begin
    bit tk, ps, mn, seen7, wrapped, reached;
    int saved_g, saved_r, saved_b, saved_scene;

    reset_n = 1'b0; mode_next = 1'b0; tick_1ms = 1'b0; pause = 1'b0;
    model_reset();
    #12;
    compare_all();
    check("reset_freq", pwm_freq, 100);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0);
      check("static_mode", mode, i);
      check("static_duty", duty_b, 333 * i);
      cycle(0, 0, 0);
    end

    cycle(1, 0, 0);
    check("party_mode", mode, 4);
    check("party_flag", party_mode_flag, 1);
    check("party_freq", pwm_freq, 1);
    check("party_scene", scene_idx, 0);
    check("party_entry_g", duty_g, 999);

    for (int t = 1; t <= 650; t++) begin
      cycle(0, 1, 0);
      if (t == 1)   begin check("tick1_r", duty_r, 1000); check("tick1_g", duty_g, 989); check("tick1_b", duty_b, 989); end
      if (t == 100) begin check("tick100_g", duty_g, 0); check("tick100_b", duty_b, 0); end
      if (t == 599) check("tick599_scene", scene_idx, 0);
      if (t == 600) check("tick600_scene", scene_idx, 1);
      if (t == 650) check("tick650_g", duty_g, 500);
    end

    seen7 = 0; wrapped = 0;
    for (int i = 0; i < 20000 && !wrapped; i++) begin
      tk = ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 9) == 0);
      cycle(0, tk, ps);
      if (m_scene == 7) seen7 = 1;
      else if (seen7 && m_scene == 0) wrapped = 1;
    end
    check("scene_wrap", wrapped, 1);
    check("scene_wrap_idx", scene_idx, 0);

    for (int i = 0; i < 20; i++) cycle(0, 1, 0);
    saved_r = m_d[0]; saved_g = m_d[1]; saved_b = m_d[2]; saved_scene = m_scene;
    for (int i = 0; i < 200; i++) cycle(0, 1, 1);
    check("pause_r", duty_r, saved_r);
    check("pause_g", duty_g, saved_g);
    check("pause_b", duty_b, saved_b);
    check("pause_scene", scene_idx, saved_scene);
    cycle(0, 1, 0);
    check("resume_g", duty_g, saved_g - STEP);

    cycle(1, 1, 0);
    check("collide_mode", mode, 0);
    check("collide_g", duty_g, 0);
    check("collide_r", duty_r, 0);
    check("collide_flag", party_mode_flag, 0);

    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    reached = 0;
    for (int i = 0; i < 300 && !reached; i++) begin
      cycle(0, 1, 0);
      reached = m_holding;
    end
    check("reach_hold", reached, 1);
    for (int i = 0; i < 50; i++) cycle(0, 1, 0);
    @(negedge clk);
    tick_1ms = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_r", duty_r, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5000; i++) begin
      mn = (m_mode == 4) ? ($urandom_range(0, 1499) == 0) : ($urandom_range(0, 19) == 0);
      tk = $urandom_range(0, 1);
      ps = ($urandom_range(0, 9) == 0);
      cycle(mn, tk, ps);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
